// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// merge_bytes works on a maximum-width word; callers size-cast to their own width.
package regfile_pkg;

  localparam int BYTE_W     = 8;
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BE_W   = MAX_DATA_W / BYTE_W;

  function automatic logic [MAX_DATA_W-1:0] merge_bytes(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] data_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res_s;
    res_s = old_word;
    for (int b = 0; b < MAX_BE_W; b++) begin
      if (be[b]) begin
        res_s[b*BYTE_W +: BYTE_W] = data_word[b*BYTE_W +: BYTE_W];
      end else begin
        res_s[b*BYTE_W +: BYTE_W] = old_word[b*BYTE_W +: BYTE_W];
      end
    end
    return res_s;
  endfunction

  function automatic bit params_ok(input int data_w, input int num_rd);
    return (data_w > 32'sd0) && ((data_w % BYTE_W) == 32'sd0) && (data_w <= MAX_DATA_W) &&
           (num_rd >= 32'sd1) && (num_rd <= 32'sd4);
  endfunction

endpackage

// File: rtl/regfile_wr_merge.sv
// Next-word merge of both write ports onto an old word: port 0 bytes first,
// then port 1 bytes on top, so port 1 wins where enables overlap.
module regfile_wr_merge
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_word,
  input  logic [DATA_WIDTH-1:0]   data0,
  input  logic [DATA_WIDTH/8-1:0] be0,
  input  logic                    hit0,
  input  logic [DATA_WIDTH-1:0]   data1,
  input  logic [DATA_WIDTH/8-1:0] be1,
  input  logic                    hit1,
  output logic [DATA_WIDTH-1:0]   next_word
);

  logic [DATA_WIDTH/8-1:0] be0_s;
  logic [DATA_WIDTH/8-1:0] be1_s;
  logic [DATA_WIDTH-1:0]   stage_s;

  // Mask enables by address match and overlay the two ports in priority order
  always_comb begin
    be0_s     = hit0 ? be0 : {(DATA_WIDTH/8){1'b0}};
    be1_s     = hit1 ? be1 : {(DATA_WIDTH/8){1'b0}};
    stage_s   = DATA_WIDTH'(merge_bytes(MAX_DATA_W'(old_word), MAX_DATA_W'(data0), MAX_BE_W'(be0_s)));
    next_word = DATA_WIDTH'(merge_bytes(MAX_DATA_W'(stage_s), MAX_DATA_W'(data1), MAX_BE_W'(be1_s)));
  end

endmodule

// File: rtl/regfile_mp_bypass.sv
// Architectural register file: two byte-enabled write ports, NUM_RD registered
// read ports, optional write-first bypass and optional hard-wired zero register.
module regfile_mp_bypass
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           wr_en0,
  input  logic [ADDR_WIDTH-1:0]          wr_addr0,
  input  logic [DATA_WIDTH-1:0]          wr_data0,
  input  logic [DATA_WIDTH/8-1:0]        wr_be0,
  input  logic                           wr_en1,
  input  logic [ADDR_WIDTH-1:0]          wr_addr1,
  input  logic [DATA_WIDTH-1:0]          wr_data1,
  input  logic [DATA_WIDTH/8-1:0]        wr_be1,
  input  logic                           rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
  output logic                           rd_valid,
  output logic                           wr_conflict
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (!params_ok(DATA_WIDTH, NUM_RD)) begin : g_param_check
    $error("regfile_mp_bypass: DATA_WIDTH must be a multiple of 8 and NUM_RD in 1..4");
  end

  logic [DATA_WIDTH-1:0]        mem_r  [DEPTH];
  logic [DATA_WIDTH-1:0]        next_s [DEPTH];
  logic [NUM_RD*DATA_WIDTH-1:0] rd_word_s;
  logic                         zero_wr0_s;
  logic                         zero_wr1_s;
  logic                         acc0_s;
  logic                         acc1_s;
  logic                         conflict_s;

  // Write acceptance; writes aimed at a hard-wired zero register are dropped entirely
  always_comb begin
    zero_wr0_s = (ZERO_REG != 32'sd0) && (wr_addr0 == {ADDR_WIDTH{1'b0}});
    zero_wr1_s = (ZERO_REG != 32'sd0) && (wr_addr1 == {ADDR_WIDTH{1'b0}});
    acc0_s     = en & wr_en0 & (|wr_be0) & ~zero_wr0_s;
    acc1_s     = en & wr_en1 & (|wr_be1) & ~zero_wr1_s;
    conflict_s = acc0_s & acc1_s & (wr_addr0 == wr_addr1) & (|(wr_be0 & wr_be1));
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    regfile_wr_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
      .old_word  (mem_r[i]),
      .data0     (wr_data0),
      .be0       (wr_be0),
      .hit0      (acc0_s && (wr_addr0 == ADDR_WIDTH'(i))),
      .data1     (wr_data1),
      .be1       (wr_be1),
      .hit1      (acc1_s && (wr_addr1 == ADDR_WIDTH'(i))),
      .next_word (next_s[i])
    );
  end

  // Each read port reuses the merge logic so bypassed data matches what storage will hold
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [DATA_WIDTH-1:0] old_s;
    logic [DATA_WIDTH-1:0] byp_s;
    logic                  zero_rd_s;

    assign addr_s    = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign old_s     = mem_r[addr_s];
    assign zero_rd_s = (ZERO_REG != 32'sd0) && (addr_s == {ADDR_WIDTH{1'b0}});

    regfile_wr_merge #(.DATA_WIDTH(DATA_WIDTH)) u_byp (
      .old_word  (old_s),
      .data0     (wr_data0),
      .be0       (wr_be0),
      .hit0      (acc0_s && (wr_addr0 == addr_s)),
      .data1     (wr_data1),
      .be1       (wr_be1),
      .hit1      (acc1_s && (wr_addr1 == addr_s)),
      .next_word (byp_s)
    );

    assign rd_word_s[k*DATA_WIDTH +: DATA_WIDTH] =
      zero_rd_s ? {DATA_WIDTH{1'b0}} : ((BYPASS != 32'sd0) ? byp_s : old_s);
  end

  // Storage, read pipeline and conflict flag; rd_data holds when no read is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
      rd_data     <= {(NUM_RD*DATA_WIDTH){1'b0}};
      rd_valid    <= 1'b0;
      wr_conflict <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= next_s[i];
      end
      rd_valid    <= en & rd_en;
      wr_conflict <= conflict_s;
      if (en & rd_en) begin
        rd_data <= rd_word_s;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Self-checking bench: dut_a is write-first with a zero register, dut_b is
// read-first without one; both have four read ports and share all inputs.
module tb_regfile_mp_bypass;

  logic        clk = 1'b0;
  logic        rst, en, wr_en0, wr_en1, rd_en;
  logic [3:0]  wr_addr0, wr_addr1, wr_be0, wr_be1;
  logic [31:0] wr_data0, wr_data1;
  logic [15:0] rd_addr;
  logic [127:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b, wr_conflict_a, wr_conflict_b;

  int checks = 0;
  int errors = 0;

  logic [15:0][31:0] m_a, m_b;
  logic [3:0][31:0]  exp_a, exp_b;
  logic              exp_valid, exp_conf_a, exp_conf_b;

  always #5 clk = ~clk;

  regfile_mp_bypass #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_RD(4), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .en(en),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0), .wr_be0(wr_be0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1), .wr_be1(wr_be1),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .wr_conflict(wr_conflict_a)
  );

  regfile_mp_bypass #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_RD(4), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .en(en),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0), .wr_be0(wr_be0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1), .wr_be1(wr_be1),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .wr_conflict(wr_conflict_b)
  );

  // Reference: registers as byte arrays, port 0 then port 1 applied in order
  function automatic logic [15:0][31:0] apply_writes(input logic [15:0][31:0] m, input bit zero);
    logic [15:0][31:0] r;
    r = m;
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_en0 && wr_be0[b] && !(zero && wr_addr0 == 4'd0)) r[wr_addr0][b*8 +: 8] = wr_data0[b*8 +: 8];
      end
      for (int b = 0; b < 4; b++) begin
        if (wr_en1 && wr_be1[b] && !(zero && wr_addr1 == 4'd0)) r[wr_addr1][b*8 +: 8] = wr_data1[b*8 +: 8];
      end
    end
    return r;
  endfunction

  function automatic bit model_conflict(input bit zero);
    return en && wr_en0 && wr_en1 && (wr_addr0 == wr_addr1) &&
           ((wr_be0 & wr_be1) != 4'd0) && !(zero && wr_addr0 == 4'd0);
  endfunction

  // Advance one clock, updating the model from the inputs presented this cycle
  task automatic step();
    logic [15:0][31:0] na, nb;
    logic [3:0] a;
    na = apply_writes(m_a, 1'b1);
    nb = apply_writes(m_b, 1'b0);
    if (rst) begin
      m_a = '0; m_b = '0; exp_a = '0; exp_b = '0;
      exp_valid = 1'b0; exp_conf_a = 1'b0; exp_conf_b = 1'b0;
    end else begin
      if (en && rd_en) begin
        for (int k = 0; k < 4; k++) begin
          a = rd_addr[k*4 +: 4];
          exp_a[k] = (a == 4'd0) ? 32'd0 : na[a];
          exp_b[k] = m_b[a];
        end
      end
      exp_valid  = en && rd_en;
      exp_conf_a = model_conflict(1'b1);
      exp_conf_b = model_conflict(1'b0);
      m_a = na;
      m_b = nb;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; en = 1'b1; wr_en0 = 1'b0; wr_en1 = 1'b0; rd_en = 1'b0;
    wr_addr0 = 4'd0; wr_addr1 = 4'd0; wr_be0 = 4'd0; wr_be1 = 4'd0;
    wr_data0 = 32'd0; wr_data1 = 32'd0; rd_addr = 16'd0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; wr_en0 = 1'b1; wr_addr0 = 4'd3; wr_data0 = 32'hFFFF_FFFF; wr_be0 = 4'hF;
    rd_en = 1'b1; rd_addr = 16'h3333;
    step(); step();
    checks++;
    if (rd_valid_a !== 1'b0 || rd_data_a !== 128'd0 || wr_conflict_a !== 1'b0) begin
      errors++; $display("FAIL reset_state: valid=%b data=%h conf=%b expected 0", rd_valid_a, rd_data_a, wr_conflict_a);
    end
    idle(); rd_en = 1'b1; rd_addr = 16'h0003;
    step();
    checks++;
    if (rd_data_a[31:0] !== 32'd0 || rd_data_b[31:0] !== 32'd0) begin
      errors++; $display("FAIL reset_drop_write: a=%h b=%h expected 0", rd_data_a[31:0], rd_data_b[31:0]);
    end
    checks++;
    if (rd_valid_a !== 1'b1 || rd_valid_b !== 1'b1) begin
      errors++; $display("FAIL rd_valid_after_read: a=%b b=%b expected 1", rd_valid_a, rd_valid_b);
    end
    idle();
    step();
    checks++;
    if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin
      errors++; $display("FAIL rd_valid_one_cycle: a=%b b=%b expected 0", rd_valid_a, rd_valid_b);
    end
  endtask

  task automatic test_byte_enable();
    idle(); wr_en0 = 1'b1; wr_addr0 = 4'd2; wr_data0 = 32'h1122_3344; wr_be0 = 4'hF;
    step();
    wr_data0 = 32'hAABB_CCDD; wr_be0 = 4'b0101;
    step();
    idle(); rd_en = 1'b1; rd_addr = 16'h0002;
    step();
    checks++;
    if (rd_data_a[31:0] !== 32'h11BB_33DD || rd_data_b[31:0] !== 32'h11BB_33DD) begin
      errors++; $display("FAIL byte_enable: a=%h b=%h expected 11bb33dd", rd_data_a[31:0], rd_data_b[31:0]);
    end
  endtask

  task automatic test_dual_merge();
    idle();
    wr_en0 = 1'b1; wr_addr0 = 4'd5; wr_data0 = 32'h0000_00AA; wr_be0 = 4'b0011;
    wr_en1 = 1'b1; wr_addr1 = 4'd5; wr_data1 = 32'hBB00_0055; wr_be1 = 4'b1001;
    step();
    checks++;
    if (wr_conflict_a !== 1'b1 || wr_conflict_b !== 1'b1) begin
      errors++; $display("FAIL conflict_pulse: a=%b b=%b expected 1", wr_conflict_a, wr_conflict_b);
    end
    idle(); rd_en = 1'b1; rd_addr = 16'h0005;
    step();
    checks++;
    if (wr_conflict_a !== 1'b0 || wr_conflict_b !== 1'b0) begin
      errors++; $display("FAIL conflict_clear: a=%b b=%b expected 0", wr_conflict_a, wr_conflict_b);
    end
    checks++;
    if (rd_data_a[31:0] !== 32'hBB00_0055 || rd_data_b[31:0] !== 32'hBB00_0055) begin
      errors++; $display("FAIL dual_merge: a=%h b=%h expected bb000055", rd_data_a[31:0], rd_data_b[31:0]);
    end
  endtask

  task automatic test_bypass();
    idle(); wr_en0 = 1'b1; wr_addr0 = 4'd7; wr_data0 = 32'hFACE_CAFE; wr_be0 = 4'hF;
    step();
    wr_data0 = 32'hCADE_BEAD; rd_en = 1'b1; rd_addr = 16'h0007;
    step();
    checks++;
    if (rd_data_a[31:0] !== 32'hCADE_BEAD) begin
      errors++; $display("FAIL bypass_write_first: got %h expected cadebead", rd_data_a[31:0]);
    end
    checks++;
    if (rd_data_b[31:0] !== 32'hFACE_CAFE) begin
      errors++; $display("FAIL bypass_read_first: got %h expected facecafe", rd_data_b[31:0]);
    end
  endtask

  task automatic test_zero_en();
    idle();
    wr_en0 = 1'b1; wr_addr0 = 4'd0; wr_data0 = 32'h1234_5678; wr_be0 = 4'hF;
    wr_en1 = 1'b1; wr_addr1 = 4'd0; wr_data1 = 32'h9ABC_DEF0; wr_be1 = 4'hF;
    rd_en = 1'b1; rd_addr = 16'h0000;
    step();
    checks++;
    if (rd_data_a[31:0] !== 32'd0 || wr_conflict_a !== 1'b0) begin
      errors++; $display("FAIL zero_reg_bypass: data=%h conf=%b expected 0 0", rd_data_a[31:0], wr_conflict_a);
    end
    checks++;
    if (wr_conflict_b !== 1'b1) begin
      errors++; $display("FAIL addr0_conflict_plain: got %b expected 1", wr_conflict_b);
    end
    idle(); rd_en = 1'b1;
    step();
    checks++;
    if (rd_data_a[31:0] !== 32'd0 || rd_data_b[31:0] !== 32'h9ABC_DEF0) begin
      errors++; $display("FAIL zero_reg_read: a=%h b=%h expected 0 9abcdef0", rd_data_a[31:0], rd_data_b[31:0]);
    end
    idle(); wr_en0 = 1'b1; wr_addr0 = 4'd1; wr_data0 = 32'h1357_9BDF; wr_be0 = 4'hF;
    step();
    en = 1'b0; wr_data0 = 32'hFFFF_FFFF; rd_en = 1'b1; rd_addr = 16'h0001;
    step();
    checks++;
    if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0 || rd_data_b[31:0] !== 32'h9ABC_DEF0) begin
      errors++; $display("FAIL en_low: valid=%b/%b data=%h expected 0/0 9abcdef0", rd_valid_a, rd_valid_b, rd_data_b[31:0]);
    end
    idle(); rd_en = 1'b1; rd_addr = 16'h0001;
    step();
    checks++;
    if (rd_data_a[31:0] !== 32'h1357_9BDF || rd_data_b[31:0] !== 32'h1357_9BDF) begin
      errors++; $display("FAIL en_low_frozen: a=%h b=%h expected 13579bdf", rd_data_a[31:0], rd_data_b[31:0]);
    end
  endtask

  task automatic test_multi_read();
    idle(); wr_en0 = 1'b1; wr_be0 = 4'hF;
    wr_addr0 = 4'd0; wr_data0 = 32'hABCD_EFAB; step();
    wr_addr0 = 4'd1; wr_data0 = 32'h7777_7777; step();
    wr_addr0 = 4'd2; wr_data0 = 32'h0643_0028; step();
    idle(); rd_en = 1'b1; rd_addr = 16'h1210;
    step();
    checks++;
    if (rd_data_b !== {32'h7777_7777, 32'h0643_0028, 32'h7777_7777, 32'hABCD_EFAB}) begin
      errors++; $display("FAIL multi_read_b: got %h", rd_data_b);
    end
    checks++;
    if (rd_data_a !== {32'h7777_7777, 32'h0643_0028, 32'h7777_7777, 32'h0000_0000}) begin
      errors++; $display("FAIL multi_read_a: got %h", rd_data_a);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 59) == 0);
      en       = ($urandom_range(0, 7) != 0);
      wr_en0   = $urandom_range(0, 1) == 1;
      wr_en1   = $urandom_range(0, 1) == 1;
      rd_en    = $urandom_range(0, 2) != 0;
      wr_addr0 = 4'($urandom_range(0, 3));
      wr_addr1 = 4'($urandom_range(0, 3));
      wr_be0   = 4'($urandom);
      wr_be1   = 4'($urandom);
      wr_data0 = $urandom;
      wr_data1 = $urandom;
      for (int k = 0; k < 4; k++) rd_addr[k*4 +: 4] = 4'($urandom_range(0, 3));
      step();
      checks++;
      if (rd_valid_a !== exp_valid || rd_valid_b !== exp_valid) begin
        errors++; $display("FAIL rand_valid[%0d]: a=%b b=%b expected %b", n, rd_valid_a, rd_valid_b, exp_valid);
      end
      checks++;
      if (wr_conflict_a !== exp_conf_a || wr_conflict_b !== exp_conf_b) begin
        errors++; $display("FAIL rand_conflict[%0d]: a=%b b=%b expected %b %b", n, wr_conflict_a, wr_conflict_b, exp_conf_a, exp_conf_b);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rd_data_a[k*32 +: 32] !== exp_a[k] || rd_data_b[k*32 +: 32] !== exp_b[k]) begin
          errors++; $display("FAIL rand_data[%0d] port %0d: a=%h b=%h expected %h %h",
                             n, k, rd_data_a[k*32 +: 32], rd_data_b[k*32 +: 32], exp_a[k], exp_b[k]);
        end
      end
    end
    idle();
  endtask

  initial begin
    m_a = '0; m_b = '0; exp_a = '0; exp_b = '0;
    exp_valid = 1'b0; exp_conf_a = 1'b0; exp_conf_b = 1'b0;
    idle();
    rst = 1'b1;
    test_reset();
    test_byte_enable();
    test_dual_merge();
    test_bypass();
    test_zero_en();
    test_multi_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp_bypass.md
Name: regfile_mp_bypass

Overview:
Parametrised successor to the team's single-write/dual-read register file. It adds:
- a configurable number of read ports;
- two write ports with per-byte enables and defined same-address priority;
- registered reads with a valid flag;
- selectable write-to-read bypass;
- an optional hard-wired zero register.

It sits as the architectural register store in the datapath, driven by issue/writeback logic.

Parameters:
DATA_WIDTH, 32, register width in bits; must be a multiple of 8.
ADDR_WIDTH, 4, address width; depth = 2**ADDR_WIDTH.
NUM_RD, 2, number of read ports; must be 1 to 4.
BYPASS, 1, 1 = write-first (same-cycle write data visible on read); 0 = read-first (old data).
ZERO_REG, 0, 1 = register 0 always reads zero and ignores writes.

Ports:
clk  input  1  rising-edge clock, the only clock
rst  input  1  synchronous, active-high reset
en  input  1  global enable; when low, no reads or writes are accepted
wr_en0  input  1  write port 0 request
wr_addr0  input  ADDR_WIDTH  write port 0 address
wr_data0  input  DATA_WIDTH  write port 0 data
wr_be0  input  DATA_WIDTH/8  write port 0 byte enables
wr_en1  input  1  write port 1 request
wr_addr1  input  ADDR_WIDTH  write port 1 address
wr_data1  input  DATA_WIDTH  write port 1 data
wr_be1  input  DATA_WIDTH/8  write port 1 byte enables
rd_en  input  1  read request, applies to all read ports
rd_addr  input  NUM_RD*ADDR_WIDTH  flattened read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  output  NUM_RD*DATA_WIDTH  flattened registered read data
rd_valid  output  1  high for exactly one cycle after an accepted read
wr_conflict  output  1  one-cycle pulse: both write ports hit the same address with overlapping byte enables

Behaviour:
- Reset: on a clk edge with rst=1, all registers, rd_data, rd_valid and wr_conflict go to 0. rst dominates en and all requests; a read or write presented in the same cycle is dropped.
- Write accept condition: en & wr_enN & (wr_beN != 0).
  - Only bytes with their be bit set are updated; the other bytes hold.
  - The update is visible in storage from the next cycle.
- Same address on both write ports:
  - bytes are merged per byte;
  - port 1 wins on bytes enabled by both ports;
  - bytes enabled by only one port take that port's data.
- wr_conflict: registered, =1 on the cycle after an accepted dual write to the same address with (wr_be0 & wr_be1) != 0; otherwise 0.
- Read accept condition: en & rd_en.
  - Latency is 1 cycle: rd_data and rd_valid update on the same edge.
  - rd_valid=1 the cycle after an accept and 0 otherwise.
  - rd_data holds its last value when no read is accepted, including when en=0.
- Bypass, BYPASS=1: if an accepted write in the same cycle targets a read port's address, that port returns the post-merge value, i.e. old bytes overlaid with port 0 bytes, then port 1 bytes.
- Bypass, BYPASS=0: the read port returns the pre-write contents.
- Multiple read ports may use the same address; each returns an identical value.
- ZERO_REG=1: writes to address 0 are discarded and do not raise wr_conflict; reads of address 0 return 0, including under bypass.
- en=0: storage is frozen, rd_valid=0 next cycle, wr_conflict=0 next cycle.
- There are no illegal addresses; the full 2**ADDR_WIDTH range is implemented.

Decomposition:
- Package regfile_pkg:
  - constant BYTE_W = 8;
  - function merge_bytes(old, data, be) returning the byte-masked overlay;
  - width-check helper used by elaboration-time assertions (DATA_WIDTH%8==0, 1<=NUM_RD<=4).
- Sub-module regfile_wr_merge:
  - combinational;
  - takes an old word plus both ports' data, be and address-match flags;
  - produces the next word.
  - It is instantiated once per write target and reused on each read port's bypass path.
- The top level holds the storage array, read pipeline registers and conflict register.

Test Plan:
1. Reset and defaults: rst=1 for 2 cycles with wr_en0=1, addr 3, data 32'hFFFF_FFFF, be 4'hF → after reset, a read of addr 3 gives rd_data port0=0, rd_valid=1 only on the cycle after rd_en.
2. Byte-enable write: write addr 2 = 32'h1122_3344 with be 4'hF, then 32'hAABB_CCDD with be 4'b0101 → read returns 32'h11BB_33DD.
3. Dual-port merge/conflict: same cycle, port0 addr 5 32'h0000_00AA be 4'b0011, port1 addr 5 32'hBB00_0055 be 4'b1001 → addr 5 = 32'hBB00_0055 (port 1 wins byte 0; byte 1 = 8'h00 from port 0), wr_conflict=1 next cycle only.
4. Bypass: with BYPASS=1, addr 7 holds 32'hFACE_CAFE; write 32'hCADE_BEAD to addr 7 while reading addr 7 → rd_data=32'hCADE_BEAD. Rerun with BYPASS=0 → 32'hFACE_CAFE.
5. Zero register and en: ZERO_REG=1, write 32'h1234_5678 to addr 0 → read 0, no conflict. en=0 with a write to addr 1 → addr 1 unchanged and rd_valid=0.
6. Multi-port read: NUM_RD=4, addresses {0,1,2,1} after preloading 32'hABCD_EFAB, 32'h7777_7777, 32'h0643_0028 → all four ports correct in the same cycle, ports 1 and 3 identical.
